// File: rtl/tristate_bus_pkg.sv
// Shared types and helpers for the tristate bus arbiter: FSM state encoding,
// counter/id width helpers and a one-hot decoder.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_e;

  localparam int MAX_N = 16;

  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Enough bits to hold values 0..maxVal inclusive.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// 'last', wrapping modulo N, so the previous owner has lowest priority.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idWidth(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] pick,
  output logic           valid
);

  logic [IDW-1:0] cand;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin control stage for a shared tristate bus with guaranteed
// all-enables-low turnaround between owners. Define BUS_KEEPER_EN to add keeper outputs.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int MAX_BURST   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         en,
  output logic [W-1:0]         dout,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
`ifdef BUS_KEEPER_EN
  ,
  output logic                 keep_en,
  output logic [W-1:0]         keep_val
`endif
);

  localparam int IDW = idWidth(N);
  localparam int BW  = cntWidth(MAX_BURST);
  localparam int TW  = cntWidth(TURN_CYCLES);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [TW-1:0]  turn_q, turn_d;
  logic [N-1:0]   en_q, en_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           busy_q, busy_d;
`ifdef BUS_KEEPER_EN
  logic           keepEn_q, keepEn_d;
  logic [W-1:0]   keepVal_q, keepVal_d;
`endif

  logic [IDW-1:0]   pick;
  logic             pickValid;
  logic             arbitrate;
  logic [MAX_N-1:0] ohFull;

  function automatic logic [W-1:0] wordAt(input logic [N*W-1:0] bus, input logic [IDW-1:0] idx);
    logic [N*W-1:0] s;
    s = bus >> (W * int'(idx));
    return s[W-1:0];
  endfunction

  rr_pick #(.N(N), .IDW(IDW)) uPick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .valid(pickValid)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    turn_d    = turn_q;
    en_d      = en_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    arbitrate = 1'b0;
    ohFull    = onehot(4'(pick));
`ifdef BUS_KEEPER_EN
    keepVal_d = keepVal_q;
`endif

    case (state_q)
      IDLE: begin
        en_d      = '0;
        busy_d    = 1'b0;
        arbitrate = 1'b1;
      end
      DRIVE: begin
        if (req[grant_q] && (burst_q < BW'(MAX_BURST))) begin
          burst_d = burst_q + BW'(1);
          dout_d  = wordAt(din, grant_q);
        end else begin
          // Release: dout keeps the last driven word, which the keeper reuses.
          en_d    = '0;
          busy_d  = 1'b0;
          turn_d  = TW'(1);
          state_d = TURN;
`ifdef BUS_KEEPER_EN
          keepVal_d = dout_q;
`endif
        end
      end
      TURN: begin
        en_d   = '0;
        busy_d = 1'b0;
        if (turn_q < TW'(TURN_CYCLES)) begin
          turn_d = turn_q + TW'(1);
        end else begin
          arbitrate = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (arbitrate && pickValid) begin
      state_d = DRIVE;
      en_d    = ohFull[N-1:0];
      dout_d  = wordAt(din, pick);
      grant_d = pick;
      last_d  = pick;
      burst_d = BW'(1);
      busy_d  = 1'b1;
    end

`ifdef BUS_KEEPER_EN
    keepEn_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(N - 1);
      grant_q <= '0;
      burst_q <= '0;
      turn_q  <= '0;
      en_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_KEEPER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      keepEn_q  <= 1'b0;
      keepVal_q <= '0;
    end else begin
      keepEn_q  <= keepEn_d;
      keepVal_q <= keepVal_d;
    end
  end

  assign keep_en  = keepEn_q;
  assign keep_val = keepVal_q;
`endif

  assign en       = en_q;
  assign dout     = dout_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: stimulus pushes model expectations,
// a monitor pops and compares each cycle, and a bus checker watches invariants.
module tb_tristate_bus_arbiter;

  localparam int N           = 4;
  localparam int W           = 8;
  localparam int MAX_BURST   = 4;
  localparam int TURN_CYCLES = 1;
  localparam int IDW         = 2;

  typedef struct packed {
    logic [N-1:0]   en;
    logic [W-1:0]   dout;
    logic [IDW-1:0] gid;
    logic           busy;
    logic           keepEn;
    logic [W-1:0]   keepVal;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic [N-1:0]     en;
  logic [W-1:0]     dout;
  logic [IDW-1:0]   grant_id;
  logic             busy;
`ifdef BUS_KEEPER_EN
  logic             keep_en;
  logic [W-1:0]     keep_val;
`endif

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who holds the bus, how long, and how many dead cycles remain.
  int         mOwner;
  int         mLast;
  int         mRun;
  int         mGapLeft;
  logic [W-1:0] mDout;
  logic       mKeepEn;
  logic [W-1:0] mKeepVal;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N(N), .W(W), .MAX_BURST(MAX_BURST), .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .en      (en),
    .dout    (dout),
    .grant_id(grant_id),
    .busy    (busy)
`ifdef BUS_KEEPER_EN
    ,
    .keep_en (keep_en),
    .keep_val(keep_val)
`endif
  );

  function automatic logic bitAt(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [W-1:0] wordOf(input logic [N*W-1:0] v, input int i);
    logic [N*W-1:0] t;
    t = v >> (i * W);
    return t[W-1:0];
  endfunction

  task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dn);
    bit wantPick;
    bit found;
    int cand;
    if (r) begin
      mOwner = -1; mLast = N - 1; mRun = 0; mGapLeft = 0;
      mDout = '0; mKeepEn = 1'b0; mKeepVal = '0;
      return;
    end
    wantPick = 1'b0;
    if (mOwner >= 0) begin
      if (bitAt(rq, mOwner) && mRun < MAX_BURST) begin
        mRun++;
        mDout = wordOf(dn, mOwner);
      end else begin
        mKeepVal = mDout;
        mOwner   = -1;
        mGapLeft = TURN_CYCLES;
      end
    end else if (mGapLeft > 0) begin
      mGapLeft--;
      wantPick = (mGapLeft == 0);
    end else begin
      wantPick = 1'b1;
    end
    if (wantPick) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (mLast + k) % N;
        if (!found && bitAt(rq, cand)) begin
          found  = 1'b1;
          mOwner = cand;
          mLast  = cand;
          mRun   = 1;
          mDout  = wordOf(dn, cand);
        end
      end
    end
    mKeepEn = (mOwner < 0) && (mGapLeft == 0);
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dn);
    exp_t e;
    rst = r;
    req = rq;
    din = dn;
    modelStep(r, rq, dn);
    e.en      = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
    e.dout    = mDout;
    e.gid     = (mOwner >= 0) ? IDW'(mOwner) : '0;
    e.busy    = (mOwner >= 0);
    e.keepEn  = mKeepEn;
    e.keepVal = mKeepVal;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] expEn,
                             input logic [W-1:0] expDout, input logic expBusy);
    tests++;
    if (en !== expEn || dout !== expDout || busy !== expBusy) begin
      fails++;
      $display("[TB] FAIL %s: en=%b dout=%h busy=%b, expected en=%b dout=%h busy=%b",
               name, en, dout, busy, expEn, expDout, expBusy);
    end
  endtask

  function automatic logic [N*W-1:0] randomDin();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v = (v << W) | (N*W)'($urandom_range(0, 255));
    return v;
  endfunction

  // Scoreboard monitor: every clock the DUT presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        tests++;
        if (en !== e.en || dout !== e.dout || busy !== e.busy ||
            (e.busy && grant_id !== e.gid)) begin
          fails++;
          $display("[TB] FAIL scoreboard @%0t: en=%b dout=%h busy=%b gid=%0d, expected en=%b dout=%h busy=%b gid=%0d",
                   $time, en, dout, busy, grant_id, e.en, e.dout, e.busy, e.gid);
        end
`ifdef BUS_KEEPER_EN
        tests++;
        if (keep_en !== e.keepEn || (e.keepEn && keep_val !== e.keepVal)) begin
          fails++;
          $display("[TB] FAIL keeper @%0t: keep_en=%b keep_val=%h, expected keep_en=%b keep_val=%h",
                   $time, keep_en, keep_val, e.keepEn, e.keepVal);
        end
`endif
      end
    end
  end

  // Bus-level invariants derived from observed enables only.
  initial begin
    logic [N-1:0] prevEn;
    int runLen;
    prevEn = '0;
    runLen = 0;
    forever begin
      @(posedge clk);
      #3;
      tests++;
      if ($countones(en) > 1 || busy !== (en != '0)) begin
        fails++;
        $display("[TB] FAIL invariant @%0t: en=%b busy=%b, expected at most one en and busy=(en!=0)",
                 $time, en, busy);
      end
      if (en != '0 && prevEn != '0 && en != prevEn) begin
        fails++;
        $display("[TB] FAIL gap @%0t: en=%b after %b, expected a zero-en cycle between owners",
                 $time, en, prevEn);
      end
      if (en != '0 && en == prevEn) runLen++;
      else if (en != '0) runLen = 1;
      else runLen = 0;
      if (runLen > MAX_BURST) begin
        fails++;
        $display("[TB] FAIL burst @%0t: run=%0d, expected at most %0d", $time, runLen, MAX_BURST);
      end
      prevEn = en;
    end
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   r;

    // Reset state.
    applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b1, '0, '0);
    checkOutput("reset", '0, '0, 1'b0);

    // Single requester hits the burst limit, turns around once, regains the bus.
    d = '0;
    d[2*W +: W] = 8'hA5;
    applyStimulus(1'b0, 4'b0100, d);
    checkOutput("t1 first grant", 4'b0100, 8'hA5, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b0100, d);
    checkOutput("t1 fourth drive", 4'b0100, 8'hA5, 1'b1);
    applyStimulus(1'b0, 4'b0100, d);
    checkOutput("t1 turn", 4'b0000, 8'hA5, 1'b0);
    applyStimulus(1'b0, 4'b0100, d);
    checkOutput("t1 regrant", 4'b0100, 8'hA5, 1'b1);

    // All requesting from IDLE: rotation 0,1,2,3,0.
    applyStimulus(1'b1, '0, '0);
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 4'b1111, randomDin());

    // Owner 1 drops after two cycles while 3 waits.
    applyStimulus(1'b1, '0, '0);
    d = randomDin();
    applyStimulus(1'b0, 4'b1010, d);
    applyStimulus(1'b0, 4'b1010, d);
    applyStimulus(1'b0, 4'b1000, d);
    checkOutput("t3 gap", 4'b0000, d[1*W +: W], 1'b0);
    applyStimulus(1'b0, 4'b1000, d);
    checkOutput("t3 next owner", 4'b1000, d[3*W +: W], 1'b1);

    // Reset mid-drive, then pointer restarts so source 0 wins.
    applyStimulus(1'b1, '0, '0);
    d = randomDin();
    applyStimulus(1'b0, 4'b0010, d);
    checkOutput("t4 drive", 4'b0010, d[1*W +: W], 1'b1);
    applyStimulus(1'b1, 4'b0010, d);
    checkOutput("t4 reset mid-drive", 4'b0000, 8'h00, 1'b0);
    applyStimulus(1'b0, 4'b0011, d);
    checkOutput("t4 first after reset", 4'b0001, d[0 +: W], 1'b1);

`ifdef BUS_KEEPER_EN
    // Keeper takes the last driven word once the bus goes idle.
    applyStimulus(1'b1, '0, '0);
    d = '0;
    d[0 +: W] = 8'h3C;
    applyStimulus(1'b0, 4'b0001, d);
    applyStimulus(1'b0, 4'b0000, d);
    tests++;
    if (keep_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t6 keeper in turn: keep_en=%b, expected 0", keep_en);
    end
    applyStimulus(1'b0, 4'b0000, d);
    tests++;
    if (keep_en !== 1'b1 || keep_val !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL t6 keeper idle: keep_en=%b keep_val=%h, expected 1 and 3c", keep_en, keep_val);
    end
`endif

    // Randomised traffic with sticky requests.
    applyStimulus(1'b1, '0, '0);
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(1'b0, r, randomDin());
    end

    repeat (3) @(posedge clk);
    #5;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
Upstream control stage for a shared tristate bus built from per-source 1-bit tristate buffer instances (in/en/y).
- Arbitrates N requesters round-robin.
- Produces a registered one-hot enable vector and the selected data word. These feed the buffer array's en and in pins.
- Inserts a turnaround gap of all-enables-low between owners, so two buffers never drive the bus in the same cycle.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width driven onto the bus
MAX_BURST, 4, maximum consecutive DRIVE cycles per grant (1..255)
TURN_CYCLES, 1, dead cycles with all en low between owners (1..7)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  request per source; level-sensitive
din  input  N*W  flattened source data; source i at din[i*W +: W]
en  output  N  one-hot (or zero) enables to tristate buffers; registered
dout  output  W  data presented to buffer in pins; registered
grant_id  output  $clog2(N)  index of current owner; valid while busy=1
busy  output  1  high while any en bit is high

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, en=0, dout=0, grant_id=0, busy=0, last owner pointer=N-1, burst count=0, turn count=0. Reset mid-DRIVE drops en on the same edge.
- States: IDLE, DRIVE, TURN.
- IDLE, req!=0:
  - Pick the first asserted req searching from last+1 upward, wrapping modulo N.
  - Next edge: en=onehot(pick), dout=din[pick], grant_id=pick, last=pick, burst=1, state=DRIVE.
  - Latency is 1 cycle from req seen to en high.
- IDLE, req==0: stay; en=0; dout holds its last value.
- DRIVE:
  - Each cycle dout reloads from din[grant_id], so dout tracks source data with 1-cycle delay.
  - If req[grant_id]=1 and burst<MAX_BURST: stay and increment burst.
  - Otherwise, next edge: en=0, busy=0, turn=1, state=TURN.
- TURN:
  - en stays 0.
  - If turn<TURN_CYCLES: increment turn.
  - At turn==TURN_CYCLES, arbitrate exactly as in IDLE. If req!=0, next edge goes to DRIVE with the new pick; otherwise go to IDLE.
- Guaranteed minimum gap between two owners' en high: TURN_CYCLES cycles.
- The same requester may regain the bus after TURN if it is the only requester.
- Simultaneous events:
  - req[grant_id] drop and burst limit in the same cycle: one TURN entry.
  - A new req arriving during TURN is considered at TURN exit.
- Invariant: $countones(en)<=1 at all times. busy == (en!=0).

Optional Feature:
Macro BUS_KEEPER_EN.
- When defined, adds outputs keep_en (1) and keep_val (W).
  - keep_en=1 only in IDLE.
  - keep_val = last dout driven in DRIVE.
  - Both are registered; reset gives keep_en=0, keep_val=0.
  - keep_en is never high in the same cycle as any en bit, nor during TURN.
  - These drive one extra tristate buffer acting as a bus keeper, so the bus does not float while idle.
- When undefined, the ports are absent and the bus is high-impedance in IDLE and TURN.

Decomposition:
- Package tristate_bus_pkg holds:
  - state enum {IDLE, DRIVE, TURN}
  - localparam helpers for id width ($clog2(N)) and burst/turn counter widths
  - onehot function
- Sub-module rr_pick: combinational round-robin picker. Inputs req[N] and last[id]; outputs pick[id] and valid.
- The top holds the FSM, counters and output registers.

Test Plan (N=4, W=8, MAX_BURST=4, TURN_CYCLES=1):
1. Reset then req=4'b0100 held, din[2]=8'hA5 -> en=4'b0100, dout=8'hA5 one cycle later; MAX_BURST limit: 4 DRIVE cycles, 1 TURN cycle (en=0), then en=4'b0100 again.
2. req=4'b1111 held from IDLE after reset -> owner sequence 0,1,2,3,0. Each owner holds 4 cycles, each followed by exactly 1 cycle of en=0.
3. Owner 1 drops req after 2 DRIVE cycles while req[3]=1 -> en=0 for 1 cycle, then en=4'b1000. Owner 1's burst is 2 cycles.
4. rst=1 asserted mid-DRIVE (en=4'b0010) -> en=0, busy=0, dout=0 at that edge. After release with req=4'b0011, first grant goes to 0 (pointer reset to 3).
5. Randomised req/din for 10k cycles -> assert $countones(en)<=1, ≥1 zero-en cycle between differing owners, no owner >4 consecutive cycles.
6. With BUS_KEEPER_EN: drive 8'h3C via owner 0, then req=0 -> keep_en=1 from the first IDLE cycle with keep_val=8'h3C. keep_en=0 during TURN and DRIVE.
